stopwatch_timer_core: RTL and testbench

//  Parametrised successor to the fixed min:sec stopwatch. It has a built-in tick prescaler,
//  a configurable minutes range, and a run-time count-up (stopwatch) or count-down (timer) mode.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_timer_core_tick_prescaler.sv | 31 +++
 rtl/stopwatch_timer_core.sv | 175 +++++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the MM:SS stopwatch/timer core.
// Status codes double as FSM state encodings so the state register can drive
// the status port directly.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_PAUSE   = 2'b10;
    localparam logic [1:0] ST_EXPIRED = 2'b11;

    localparam int              SEC_W   = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    // Saturate a preset seconds value to the legal 0..59 range
    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] value);
        return (value > SEC_MAX) ? SEC_MAX : value;
    endfunction

endpackage

// File: rtl/stopwatch_timer_core_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
// The count holds while en is low, so a partial second survives a pause.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, wrapping at the last cycle of each second
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/stopwatch_timer_core.sv
// MM:SS stopwatch / countdown timer with built-in tick prescaler.
// Optional feature macro: LAP_CAPTURE_EN adds lap_min/lap_sec, loaded by a
// start command while running. Without it, start while running is ignored.
module stopwatch_timer_core
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MIN_W         = 8,
    parameter int MAX_MIN       = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             reset,
    input  logic             mode,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [1:0]       status,
    output logic             event_p
`ifdef LAP_CAPTURE_EN
    ,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec
`endif
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

    logic [1:0]       state, state_n;
    logic [MIN_W-1:0] min_n;
    logic [5:0]       sec_n;
    logic             ev_n;
    logic             mode_q, mode_n;

    logic cmd_reset, cmd_stop, cmd_load, cmd_start;
    logic is_zero, start_go, stop_go, load_go;
    logic pre_en, pre_clr, tick;
    logic [MIN_W-1:0] min_clamped;
    logic [5:0]       sec_clamped;

    // One command wins per cycle: reset, then stop, then load, then start
    assign cmd_reset = reset;
    assign cmd_stop  = stop  && !reset;
    assign cmd_load  = load  && !reset && !stop;
    assign cmd_start = start && !reset && !stop && !load;

    assign is_zero  = (minutes == '0) && (seconds == '0);
    assign start_go = cmd_start && (((state == ST_IDLE) && !(mode && is_zero)) ||
                                    (state == ST_PAUSE));
    assign stop_go  = cmd_stop && (state == ST_RUN);
    assign load_go  = cmd_load && ((state == ST_IDLE) || (state == ST_PAUSE));

    assign min_clamped = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
    assign sec_clamped = clamp_sec(load_sec);

    // A stop or reset in a tick cycle must not consume the pending tick
    assign pre_en  = (state == ST_RUN) && !cmd_reset && !cmd_stop;
    assign pre_clr = cmd_reset || (start_go && (state == ST_IDLE));

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (tick)
    );

    // Next-state, next-count and event decision for the control FSM
    always_comb begin
        state_n = state;
        min_n   = minutes;
        sec_n   = seconds;
        ev_n    = 1'b0;
        mode_n  = mode_q;
        if (cmd_reset) begin
            state_n = ST_IDLE;
            min_n   = '0;
            sec_n   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (load_go) begin
                        min_n = min_clamped;
                        sec_n = sec_clamped;
                    end else if (start_go) begin
                        state_n = ST_RUN;
                        if (state == ST_IDLE) begin
                            mode_n = mode;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop_go) begin
                        state_n = ST_PAUSE;
                    end else if (tick) begin
                        if (!mode_q) begin
                            if (seconds == SEC_MAX) begin
                                sec_n = '0;
                                if (minutes == MAX_MIN_V) begin
                                    min_n = '0;
                                    ev_n  = 1'b1;
                                end else begin
                                    min_n = minutes + MIN_W'(1);
                                end
                            end else begin
                                sec_n = seconds + 6'd1;
                            end
                        end else begin
                            if (is_zero) begin
                                state_n = ST_EXPIRED;
                                ev_n    = 1'b1;
                            end else if (seconds == '0) begin
                                sec_n = SEC_MAX;
                                min_n = minutes - MIN_W'(1);
                            end else begin
                                sec_n = seconds - 6'd1;
                                if ((minutes == '0) && (seconds == 6'd1)) begin
                                    state_n = ST_EXPIRED;
                                    ev_n    = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register state, count, event pulse and latched direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            minutes <= '0;
            seconds <= '0;
            event_p <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state   <= state_n;
            minutes <= min_n;
            seconds <= sec_n;
            event_p <= ev_n;
            mode_q  <= mode_n;
        end
    end

    assign status = state;

`ifdef LAP_CAPTURE_EN
    logic lap_go;
    assign lap_go = cmd_start && (state == ST_RUN);

    // Snapshot the running count on a start command; reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_min <= '0;
            lap_sec <= '0;
        end else if (cmd_reset) begin
            lap_min <= '0;
            lap_sec <= '0;
        end else if (lap_go) begin
            lap_min <= minutes;
            lap_sec <= seconds;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Self-checking bench for stopwatch_timer_core (TICKS_PER_SEC=4, MAX_MIN=2).
// Honours LAP_CAPTURE_EN when defined for the build.
module tb_stopwatch_timer_core;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_EXP   = 2'b11;

`ifdef LAP_CAPTURE_EN
    localparam int LAP_M = 1;
    localparam int LAP_S = 23;
`else
    localparam int LAP_M = 0;
    localparam int LAP_S = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, reset, mode, load;
    logic [7:0] load_min;
    logic [5:0] load_sec;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic       event_p;
    logic [7:0] lap_min;
    logic [5:0] lap_sec;

    typedef struct {
        string       name;
        int          at;
        logic [30:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stopwatch_timer_core #(
        .TICKS_PER_SEC(4),
        .MIN_W        (8),
        .MAX_MIN      (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .reset   (reset),
        .mode    (mode),
        .load    (load),
        .load_min(load_min),
        .load_sec(load_sec),
        .minutes (minutes),
        .seconds (seconds),
        .status  (status),
        .event_p (event_p)
`ifdef LAP_CAPTURE_EN
        ,
        .lap_min (lap_min),
        .lap_sec (lap_sec)
`endif
    );

`ifndef LAP_CAPTURE_EN
    assign lap_min = 8'd0;
    assign lap_sec = 6'd0;
`endif

    function automatic logic [30:0] mk(logic [1:0] st, int m, int s, logic ev,
                                       int lm = 0, int ls = 0);
        return {st, 8'(m), 6'(s), ev, 8'(lm), 6'(ls)};
    endfunction

    function automatic logic [30:0] snap();
        return {status, minutes, seconds, event_p, lap_min, lap_sec};
    endfunction

    function automatic void push(string n, int at, logic [30:0] v);
        exp_t e;
        e.name = n;
        e.at   = at;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Advance one clock, sample point is 1 time unit after the edge;
    // single-cycle commands are dropped after each edge
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        load  = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        start = 0; stop = 0; reset = 0; mode = 0; load = 0;
        load_min = 0; load_sec = 0;
        repeat (2) @(posedge clk);
        #1;
        push("reset_state", 0, mk(S_IDLE, 0, 0, 0));
        e = sb.pop_front(); checks++;
        if (snap() !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
        end
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        push("async_reset_midrun", 0, mk(S_IDLE, 0, 0, 0));
        e = sb.pop_front(); checks++;
        if (snap() !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_count_up();
        exp_t e;
        mode = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            case (k)
                1: begin
                    start = 1'b1;
                    push("up_run_c1",   1, mk(S_RUN, 0, 0, 0));
                    push("up_hold_c4",  4, mk(S_RUN, 0, 0, 0));
                    push("up_sec1_c5",  5, mk(S_RUN, 0, 1, 0));
                    push("up_sec2_c9",  9, mk(S_RUN, 0, 2, 0));
                end
                10: begin
                    reset = 1'b1;
                    push("up_clear", 10, mk(S_IDLE, 0, 0, 0));
                end
                default: begin
                end
            endcase
            step();
            while (sb.size() != 0 && sb[0].at <= k) begin
                e = sb.pop_front(); checks++;
                if (snap() !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("[TB] FAIL up_leftover: %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_up_wrap();
        exp_t e;
        mode = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            case (k)
                1: begin
                    load = 1'b1; load_min = 8'd2; load_sec = 6'd59;
                    push("wrap_load", 1, mk(S_IDLE, 2, 59, 0));
                end
                2: begin
                    start = 1'b1;
                    push("wrap_run",     2, mk(S_RUN, 2, 59, 0));
                    push("wrap_pre",     5, mk(S_RUN, 2, 59, 0));
                    push("wrap_event",   6, mk(S_RUN, 0, 0, 1));
                    push("wrap_ev_drop", 7, mk(S_RUN, 0, 0, 0));
                end
                8: begin
                    reset = 1'b1;
                    push("wrap_clear", 8, mk(S_IDLE, 0, 0, 0));
                end
                default: begin
                end
            endcase
            step();
            while (sb.size() != 0 && sb[0].at <= k) begin
                e = sb.pop_front(); checks++;
                if (snap() !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("[TB] FAIL wrap_leftover: %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_pause_resume();
        exp_t e;
        mode = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            case (k)
                1: begin
                    start = 1'b1;
                    push("pr_run", 1, mk(S_RUN, 0, 0, 0));
                end
                4: begin
                    stop = 1'b1;
                    push("pr_paused",      4, mk(S_PAUSE, 0, 0, 0));
                    push("pr_still_pause", 13, mk(S_PAUSE, 0, 0, 0));
                end
                14: begin
                    start = 1'b1;
                    push("pr_resumed",   14, mk(S_RUN, 0, 0, 0));
                    push("pr_resume_p1", 15, mk(S_RUN, 0, 0, 0));
                    push("pr_resume_p2", 16, mk(S_RUN, 0, 1, 0));
                end
                17: begin
                    reset = 1'b1;
                    push("pr_clear", 17, mk(S_IDLE, 0, 0, 0));
                end
                default: begin
                end
            endcase
            step();
            while (sb.size() != 0 && sb[0].at <= k) begin
                e = sb.pop_front(); checks++;
                if (snap() !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("[TB] FAIL pr_leftover: %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        mode = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            case (k)
                1: begin
                    load = 1'b1; load_min = 8'd1; load_sec = 6'd0;
                    push("dn_load", 1, mk(S_IDLE, 1, 0, 0));
                end
                2: begin
                    start = 1'b1;
                    push("dn_run",   2, mk(S_RUN, 1, 0, 0));
                    push("dn_pre",   5, mk(S_RUN, 1, 0, 0));
                    push("dn_0059",  6, mk(S_RUN, 0, 59, 0));
                    push("dn_0058", 10, mk(S_RUN, 0, 58, 0));
                end
                11: begin
                    stop = 1'b1;
                    push("dn_pause", 11, mk(S_PAUSE, 0, 58, 0));
                end
                12: begin
                    load = 1'b1; load_min = 8'd0; load_sec = 6'd1;
                    push("dn_load_0001", 12, mk(S_PAUSE, 0, 1, 0));
                end
                13: begin
                    start = 1'b1;
                    push("dn_rerun",   13, mk(S_RUN, 0, 1, 0));
                    push("dn_pre_exp", 16, mk(S_RUN, 0, 1, 0));
                    push("dn_expired", 17, mk(S_EXP, 0, 0, 1));
                    push("dn_ev_drop", 18, mk(S_EXP, 0, 0, 0));
                end
                19: begin
                    start = 1'b1;
                    push("exp_ign_start", 19, mk(S_EXP, 0, 0, 0));
                end
                20: begin
                    load = 1'b1; load_min = 8'd1; load_sec = 6'd1;
                    push("exp_ign_load", 20, mk(S_EXP, 0, 0, 0));
                end
                21: begin
                    stop = 1'b1;
                    push("exp_ign_stop", 21, mk(S_EXP, 0, 0, 0));
                end
                22: begin
                    reset = 1'b1;
                    push("exp_reset", 22, mk(S_IDLE, 0, 0, 0));
                end
                23: begin
                    start = 1'b1;
                    push("dn_zero_start_c1", 23, mk(S_IDLE, 0, 0, 0));
                    push("dn_zero_start_c2", 24, mk(S_IDLE, 0, 0, 0));
                end
                default: begin
                end
            endcase
            step();
            while (sb.size() != 0 && sb[0].at <= k) begin
                e = sb.pop_front(); checks++;
                if (snap() !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("[TB] FAIL dn_leftover: %0d pending expected 0", sb.size());
            sb.delete();
        end
        mode = 1'b0;
    endtask

    task automatic test_load_clamp();
        exp_t e;
        mode = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            case (k)
                1: begin
                    load = 1'b1; load_min = 8'd7; load_sec = 6'd63;
                    push("ld_clamp_both", 1, mk(S_IDLE, 2, 59, 0));
                end
                2: begin
                    start = 1'b1;
                    push("ld_run", 2, mk(S_RUN, 2, 59, 0));
                end
                3: begin
                    load = 1'b1; load_min = 8'd1; load_sec = 6'd10;
                    push("ld_ign_running", 3, mk(S_RUN, 2, 59, 0));
                end
                4: begin
                    reset = 1'b1;
                    push("ld_clear", 4, mk(S_IDLE, 0, 0, 0));
                end
                5: begin
                    load = 1'b1; load_min = 8'd1; load_sec = 6'd60;
                    push("ld_clamp_sec", 5, mk(S_IDLE, 1, 59, 0));
                end
                6: begin
                    load = 1'b1; load_min = 8'd3; load_sec = 6'd10;
                    push("ld_clamp_min", 6, mk(S_IDLE, 2, 10, 0));
                end
                7: begin
                    load = 1'b1; start = 1'b1; load_min = 8'd0; load_sec = 6'd3;
                    push("ld_beats_start",    7, mk(S_IDLE, 0, 3, 0));
                    push("ld_beats_start_c2", 8, mk(S_IDLE, 0, 3, 0));
                end
                9: begin
                    reset = 1'b1;
                    push("ld_clear2", 9, mk(S_IDLE, 0, 0, 0));
                end
                default: begin
                end
            endcase
            step();
            while (sb.size() != 0 && sb[0].at <= k) begin
                e = sb.pop_front(); checks++;
                if (snap() !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("[TB] FAIL ld_leftover: %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_collisions();
        exp_t e;
        mode = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            case (k)
                1: begin
                    load = 1'b1; load_min = 8'd1; load_sec = 6'd20;
                    push("co_load", 1, mk(S_IDLE, 1, 20, 0));
                end
                2: begin
                    start = 1'b1;
                    push("co_run",   2, mk(S_RUN, 1, 20, 0));
                    push("co_0121",  6, mk(S_RUN, 1, 21, 0));
                    push("co_0123", 14, mk(S_RUN, 1, 23, 0));
                end
                15: begin
                    start = 1'b1;
                    push("co_lap_capture", 15, mk(S_RUN, 1, 23, 0, LAP_M, LAP_S));
                    push("co_lap_continue", 18, mk(S_RUN, 1, 24, 0, LAP_M, LAP_S));
                end
                22: begin
                    stop = 1'b1;
                    push("co_stop_on_tick", 22, mk(S_PAUSE, 1, 24, 0, LAP_M, LAP_S));
                end
                23: begin
                    start = 1'b1;
                    push("co_resume",       23, mk(S_RUN, 1, 24, 0, LAP_M, LAP_S));
                    push("co_held_tick",    24, mk(S_RUN, 1, 25, 0, LAP_M, LAP_S));
                    push("co_before_reset", 27, mk(S_RUN, 1, 25, 0, LAP_M, LAP_S));
                end
                28: begin
                    reset = 1'b1; stop = 1'b1;
                    push("co_reset_stop_tick", 28, mk(S_IDLE, 0, 0, 0));
                end
                default: begin
                end
            endcase
            step();
            while (sb.size() != 0 && sb[0].at <= k) begin
                e = sb.pop_front(); checks++;
                if (snap() !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, snap(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("[TB] FAIL co_leftover: %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_count_up();
        test_up_wrap();
        test_pause_resume();
        test_count_down();
        test_load_clamp();
        test_collisions();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
